// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write arbiter and its round-robin arbiter.
package sccb_pkg;

    // Transfer sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        W_SLV,
        W_ADDR,
        W_DATA,
        GAP
    } state_t;

    // i2c_top ack encoding: bit 1 is the 9th-bit tick, bit 0 is the ACK level.
    localparam logic [1:0] ACK_OK   = 2'b11;
    localparam logic [1:0] ACK_NACK = 2'b10;

    // i2c_top state value when the master is idle.
    localparam logic [3:0] I2C_IDLE = 4'd0;

    // OV7670 write address.
    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h42;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer past the winner when the grant is consumed.
module rr_arbiter
    import sccb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;

    // Wrapping search from the pointer and next-pointer computation.
    always_comb begin
        int cand;
        // NOTE: every signal gets a default before the case/if logic so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = IDX_W'(cand);
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Shares one SCCB/I2C master between several register-write requesters.
// Each grant sends slave address, register address and data, then holds a
// fixed idle gap before the master can be granted again.
module sccb_write_arbiter
    import sccb_pkg::*;
#(
    parameter int         NUM_REQ     = 4,
    parameter logic [7:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         GAP_CYCLES  = 65536,
    parameter int         ACK_TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   nack,
    output logic                 timeout,
    output logic                 busy,
    output logic                 i2c_start,
    output logic                 i2c_stop,
    output logic [7:0]           i2c_wr_data,
    input  logic [1:0]           i2c_ack,
    input  logic [3:0]           i2c_state
);

    localparam int IDX_W = cnt_width(NUM_REQ);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int TO_W  = cnt_width(ACK_TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             gap_ok_q, gap_ok_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_advance;
    logic               ack_tick;
    logic               to_expired;

    assign ack_tick   = i2c_ack[1];
    assign to_expired = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Next-state, counters and master-side strobes; outputs react to the ack tick in the same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        gap_cnt_d   = gap_cnt_q;
        gap_ok_d    = gap_ok_q;
        to_cnt_d    = to_cnt_q;
        arb_advance = 1'b0;
        req_ready   = '0;
        done        = '0;
        nack        = '0;
        timeout     = 1'b0;
        busy        = (state_q != IDLE);
        i2c_start   = 1'b0;
        i2c_stop    = 1'b0;
        i2c_wr_data = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid && gap_ok_q && i2c_state == I2C_IDLE) begin
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (|arb_grant) begin
                    req_ready   = arb_grant;
                    arb_advance = 1'b1;
                    idx_d       = arb_idx;
                    addr_d      = req_addr[{arb_idx, 3'b000} +: 8];
                    data_d      = req_data[{arb_idx, 3'b000} +: 8];
                    state_d     = START;
                end else begin
                    // Requester withdrew before the grant; nothing was accepted.
                    state_d = IDLE;
                end
            end

            START: begin
                i2c_start   = 1'b1;
                i2c_wr_data = SLAVE_ADDR;
                to_cnt_d    = '0;
                state_d     = W_SLV;
            end

            W_SLV, W_ADDR, W_DATA: begin
                if (ack_tick) begin
                    to_cnt_d = '0;
                    if (i2c_ack == ACK_OK) begin
                        if (state_q == W_SLV) begin
                            i2c_wr_data = addr_q;
                            state_d     = W_ADDR;
                        end else if (state_q == W_ADDR) begin
                            i2c_wr_data = data_q;
                            state_d     = W_DATA;
                        end else begin
                            i2c_stop   = 1'b1;
                            done[idx_q] = 1'b1;
                            state_d    = GAP;
                            gap_cnt_d  = '0;
                            gap_ok_d   = 1'b0;
                        end
                    end else if (i2c_ack == ACK_NACK) begin
                        i2c_stop    = 1'b1;
                        nack[idx_q] = 1'b1;
                        state_d     = GAP;
                        gap_cnt_d   = '0;
                        gap_ok_d    = 1'b0;
                    end
                end else if (to_expired) begin
                    i2c_stop    = 1'b1;
                    nack[idx_q] = 1'b1;
                    timeout     = 1'b1;
                    state_d     = GAP;
                    gap_cnt_d   = '0;
                    gap_ok_d    = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d  = IDLE;
                    gap_ok_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset cycle abandons the transfer without reporting it.
        if (rst) begin
            req_ready   = '0;
            done        = '0;
            nack        = '0;
            timeout     = 1'b0;
            busy        = 1'b0;
            i2c_start   = 1'b0;
            i2c_stop    = 1'b0;
            i2c_wr_data = '0;
        end
    end

    // Control state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            gap_ok_q  <= 1'b1;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            gap_ok_q  <= gap_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Latched write payload.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are always loaded in GRANT before being driven out.
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
